regfile_sequencer: RTL and testbench
====================================

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 Parameter: CNT_W, 16, width of the retired-instruction counter.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 Port: start  input  1  request to execute one R-type operation; sampled only in IDLE or DONE.
REQ-005 Port: rs, rt, rd  input  5 each  source and destination register indices, latched when start is accepted.
REQ-006 Port: alu_result  input  32  combinational ALU output driven from register-file read data.
REQ-007 Port: rf_rdata1  input  32  register-file read port 1 data, combinational from rf_raddr1.
REQ-008 Port: rf_we  output  1  register-file write enable.
REQ-009 Port: rf_raddr1, rf_raddr2, rf_waddr  output  5 each  register-file read/write addresses.
REQ-010 Port: rf_wdata  output  32  register-file write data.
REQ-011 Port: busy  output  1  high in every state except IDLE.
REQ-012 Port: done  output  1  one-cycle pulse when result is valid.
REQ-013 Port: result  output  32  value read back from rd; holds until next done.
REQ-014 Port: retired  output  CNT_W  count of completed operations.

Function
REQ-015 The FSM SHALL have states IDLE, READ, WRITE, READBACK, DONE, binary-encoded.
REQ-016 All outputs SHALL be decoded from state and internal registers only; no combinational path from start, rs, rt, rd to any output.
REQ-017 IDLE: start=1 latches rs/rt/rd and moves to READ; start=0 stays in IDLE.
REQ-018 READ: rf_raddr1=rs_q, rf_raddr2=rt_q, rf_we=0; alu_result captured into wdata_q at end of cycle; next WRITE.
REQ-019 WRITE: rf_waddr=rd_q, rf_wdata=wdata_q, rf_we=1 unless rd_q==0 (rf_we=0, r0 never written); next READBACK.
REQ-020 READBACK: rf_raddr1=rd_q, rf_raddr2=0, rf_we=0; rf_rdata1 captured into result at end of cycle; next DONE.
REQ-021 DONE: done=1, retired increments by 1 (wraps modulo 2^CNT_W); start=1 latches new operands and moves to READ, else IDLE.
REQ-022 Latency: start accepted at edge N -> done=1 in cycle after edge N+3; throughput one operation per 4 cycles with back-to-back start.
REQ-023 start in READ, WRITE or READBACK SHALL be ignored (no queuing, no latch of operands).
REQ-024 rf_we SHALL be high for exactly one cycle per operation with rd_q!=0 and never outside WRITE.
REQ-025 In states other than READ/READBACK, rf_raddr1 and rf_raddr2 SHALL be 0; outside WRITE, rf_waddr=0 and rf_wdata=0.
REQ-026 rd_q==rs_q or rd_q==rt_q SHALL need no special handling: read occurs in READ, before WRITE.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE and clear rs_q, rt_q, rd_q, wdata_q, result, retired to 0; busy=0, done=0, rf_we=0 in the following cycle.
REQ-028 rst SHALL take priority over start and over any in-flight operation; an interrupted operation SHALL neither write the register file after the reset edge nor increment retired.
REQ-029 After reset release, the first start SHALL be accepted on the first edge where rst=0 and start=1.

Verification
REQ-030 Single op: r1=5, r2=7, ALU add, start with rs=1, rt=2, rd=3 -> rf_we=1 once with waddr=3, wdata=12; done after 4 cycles; result=12; retired=1.
REQ-031 r0 target: start with rd=0, alu_result=0x55 -> rf_we stays 0 throughout; result=0 (model r0=0); done pulses; retired increments.
REQ-032 Back-to-back: start held high for 3 operations -> done pulses 4 cycles apart, busy never drops, retired=3.
REQ-033 Busy-drop: start pulsed with rd=9 during WRITE of an op with rd=4 -> only r4 written; no second done.
REQ-034 Reset mid-op: rst asserted in READ state -> no rf_we pulse, done never asserts, result=0, retired=0, state IDLE.
REQ-035 Wrap: preload/drive 2^CNT_W-1 completions (or CNT_W=4 with 16 ops) -> retired returns to 0 on the next done.

Source files
------------

// File: rtl/regfile_sequencer.sv
// Multi-cycle sequencer for one R-type operation: read operands, write the ALU result,
// read the destination back, then report it with a done pulse and a retired-op count.
module regfile_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic [4:0]       rd,
    input  logic [31:0]      alu_result,
    input  logic [31:0]      rf_rdata1,
    output logic             rf_we,
    output logic [4:0]       rf_raddr1,
    output logic [4:0]       rf_raddr2,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             busy,
    output logic             done,
    output logic [31:0]      result,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        WRITE    = 3'd2,
        READBACK = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [4:0]       rs_q, rt_q, rd_q;
    logic [31:0]      wdata_q;
    logic [31:0]      result_q;
    logic [CNT_W-1:0] retired_q;
    logic             accept;

    // Operands are only taken when no operation is in flight.
    assign accept = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            wdata_q   <= '0;
            result_q  <= '0;
            retired_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rs_q <= rs;
                rt_q <= rt;
                rd_q <= rd;
            end
            if (state == READ) begin
                wdata_q <= alu_result;
            end
            // Count on entry to DONE so retired and result agree while done is high.
            if (state == READBACK) begin
                result_q  <= rf_rdata1;
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rf_we     = 1'b0;
        rf_raddr1 = 5'd0;
        rf_raddr2 = 5'd0;
        rf_waddr  = 5'd0;
        rf_wdata  = 32'd0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = READ;
            end
            READ: begin
                rf_raddr1 = rs_q;
                rf_raddr2 = rt_q;
                state_nxt = WRITE;
            end
            WRITE: begin
                rf_waddr  = rd_q;
                rf_wdata  = wdata_q;
                rf_we     = (rd_q != 5'd0);
                state_nxt = READBACK;
            end
            READBACK: begin
                rf_raddr1 = rd_q;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? READ : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign result  = result_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Randomized scoreboard bench for regfile_sequencer with a behavioural register-file model.
module tb_regfile_sequencer;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [4:0]       rs, rt, rd;
    logic [31:0]      alu_result, rf_rdata1;
    logic             rf_we;
    logic [4:0]       rf_raddr1, rf_raddr2, rf_waddr;
    logic [31:0]      rf_wdata;
    logic             busy, done;
    logic [31:0]      result;
    logic [CNT_W-1:0] retired;

    always #5 clk = ~clk;

    regfile_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .rs(rs), .rt(rt), .rd(rd),
        .alu_result(alu_result), .rf_rdata1(rf_rdata1), .rf_we(rf_we),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .busy(busy), .done(done), .result(result),
        .retired(retired)
    );

    // Environment: a real register file (r0 hardwired to zero) and an adding ALU.
    logic [31:0] regs [32];
    assign rf_rdata1  = (rf_raddr1 == 5'd0) ? 32'd0 : regs[rf_raddr1];
    assign alu_result = ((rf_raddr1 == 5'd0) ? 32'd0 : regs[rf_raddr1])
                      + ((rf_raddr2 == 5'd0) ? 32'd0 : regs[rf_raddr2]);
    always @(posedge clk) if (rf_we && rf_waddr != 5'd0) regs[rf_waddr] <= rf_wdata;

    // Reference model and scoreboard queues.
    logic [31:0]      mregs [32];
    logic [CNT_W-1:0] mcnt;
    logic [31:0]      exp_res_q [$];
    logic [CNT_W-1:0] exp_cnt_q [$];
    logic [36:0]      exp_wr_q  [$];
    int               acc_cyc_q [$];

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    bit b2b_mode = 1'b0;
    int b2b_prev = -1;
    int b2b_dones = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (exp_res_q.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
                end else begin
                    check("result", result, exp_res_q.pop_front());
                    check("retired", 32'(retired), 32'(exp_cnt_q.pop_front()));
                    check("latency", 32'(cyc - acc_cyc_q.pop_front()), 32'd3);
                end
                if (b2b_mode) begin
                    if (b2b_prev >= 0) check("done_gap", 32'(cyc - b2b_prev), 32'd4);
                    b2b_prev = cyc;
                    b2b_dones++;
                    if (b2b_dones == 3) b2b_mode = 1'b0;
                end
            end
            if (rf_we) begin
                if (exp_wr_q.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL unexpected_write: got waddr=%0d wdata=%0h expected no write", rf_waddr, rf_wdata);
                end else begin
                    logic [36:0] w;
                    w = exp_wr_q.pop_front();
                    check("waddr", 32'(rf_waddr), 32'(w[36:32]));
                    check("wdata", rf_wdata, w[31:0]);
                end
            end
            if (b2b_mode) check("busy_b2b", 32'(busy), 32'd1);
            if (!busy) check("idle_outputs", 32'({rf_we, done, rf_raddr1, rf_raddr2, rf_waddr}) | rf_wdata, 32'd0);
        end
    end

    task automatic issue_op(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d, input bit expect_done);
        logic [31:0] v;
        int k;
        for (k = 0; k < 20; k++) begin
            if (!busy || done) break;
            @(posedge clk); #1;
        end
        if (k == 20) begin
            nchk++; nerr++;
            $display("FAIL issue_timeout: got busy=%0b expected ready within 20 cycles", busy);
        end
        start = 1'b1; rs = a; rt = b; rd = d;
        @(posedge clk); #1;
        start = 1'b0;
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
        if (expect_done) begin
            v = mregs[a] + mregs[b];
            if (d != 5'd0) begin
                mregs[d] = v;
                exp_wr_q.push_back({d, v});
            end
            mcnt = mcnt + CNT_W'(1);
            exp_res_q.push_back(mregs[d]);
            exp_cnt_q.push_back(mcnt);
            acc_cyc_q.push_back(cyc);
        end
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 100; k++) begin
            if (exp_res_q.size() == 0 && exp_wr_q.size() == 0) break;
            @(posedge clk); #1;
        end
        if (k == 100) begin
            nchk++; nerr++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_res_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            logic [31:0] v;
            v = (i == 0) ? 32'd0 : (i == 1) ? 32'd5 : (i == 2) ? 32'd7 : $urandom;
            regs[i] <= v;
            mregs[i] = v;
        end
        mcnt = '0;
        rst = 1'b1; start = 1'b0; rs = '0; rt = '0; rd = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        rst = 1'b0;

        // Single add r3 = r1 + r2, then an r0-target op.
        issue_op(5'd1, 5'd2, 5'd3, 1'b1);
        drain();
        check("r3_value", regs[3], 32'd12);
        issue_op(5'd3, 5'd1, 5'd0, 1'b1);
        drain();

        // A start pulse during WRITE must be ignored.
        issue_op(5'd1, 5'd3, 5'd4, 1'b1);
        @(posedge clk); #1;
        start = 1'b1; rd = 5'd9; rs = 5'd2; rt = 5'd2;
        @(posedge clk); #1;
        start = 1'b0;
        drain();
        check("r9_untouched", regs[9], mregs[9]);
        check("r4_value", regs[4], 32'd17);

        // Reset while in READ abandons the operation.
        issue_op(5'd1, 5'd2, 5'd5, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_res_q.delete(); exp_cnt_q.delete(); exp_wr_q.delete(); acc_cyc_q.delete();
        mcnt = '0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_we", 32'(rf_we), 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_retired", 32'(retired), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("r5_untouched", regs[5], mregs[5]);

        // Three back-to-back operations.
        b2b_prev = -1; b2b_dones = 0;
        issue_op(5'd1, 5'd2, 5'd6, 1'b1);
        b2b_mode = 1'b1;
        issue_op(5'd6, 5'd6, 5'd6, 1'b1);
        issue_op(5'd6, 5'd1, 5'd7, 1'b1);
        drain();
        check("b2b_finished", 32'(b2b_mode), 32'd0);
        check("b2b_retired", 32'(retired), 32'd3);

        // Random operations; enough of them to wrap the 4-bit counter twice.
        for (int n = 0; n < 30; n++) begin
            issue_op(5'($urandom), 5'($urandom), 5'($urandom_range(0, 31)), 1'b1);
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();
        check("final_retired", 32'(retired), 32'(mcnt));
        for (int i = 0; i < 32; i++) check("final_regs", regs[i], mregs[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
